cpu_ex_muldiv: RTL and testbench
================================

Name: cpu_ex_muldiv

Overview:
Iterative multiply/divide unit with architectural HI/LO registers, sitting in the EX stage alongside the ALU, directly upstream of the MEM stage. EX forwards hi/lo into its alu_result path for MFHI/MFLO, which MEM latches for writeback. The unit raises a stall request while a multi-cycle operation is in flight and a dependent instruction reaches EX. An exception flush can abort an operation in progress.

Parameters:
WIDTH, 32, operand and HI/LO width. The count register is sized clog2(WIDTH)+1.

Ports:
clk  input  1  global clock; all state updates on posedge
clr_n  input  1  asynchronous active-low reset
op_valid  input  1  EX holds a mul/div/mthi/mtlo instruction this cycle
op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NONE
src_a  input  WIDTH  rs operand (dividend/multiplicand; MTHI/MTLO data)
src_b  input  WIDTH  rt operand (divisor/multiplier)
hilo_read  input  1  EX holds an MFHI/MFLO this cycle
flush  input  1  exception flush from CP0 path
busy  output  1  operation in flight
stall_req  output  1  freeze IF/ID/EX this cycle
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (clr_n low, asynchronous): state IDLE, count 0, hi 0, lo 0, all working registers 0. busy=0.
- States: IDLE, CALC, FIX. busy = (state != IDLE). stall_req = busy & (op_valid | hilo_read), combinational.
- Accept: in IDLE, on a posedge with op_valid=1, flush=0 and op in 1..4, latch operands.
  - Signed ops latch magnitudes plus result-sign flags; unsigned ops latch raw values.
  - Load count=0 and go to CALC.
- CALC: one bit per cycle (shift-add multiply; restoring divide). count increments each cycle. After the edge where count reaches WIDTH-1, go to FIX. This gives exactly WIDTH CALC cycles.
- FIX: apply sign correction and write hi/lo, then go to IDLE.
  - Accept at edge T: hi/lo change at edge T+WIDTH+1 (T+33 at default width).
  - busy is high for cycles T+1 through T+33.
- MULT/MULTU result: hi = upper WIDTH bits of the 2*WIDTH product; lo = lower WIDTH bits. MULT negates the 64-bit product when the operand signs differ.
- DIV/DIVU result: lo = quotient, hi = remainder.
  - Signed quotient is negated when the operand signs differ; signed remainder takes the sign of the dividend.
  - -2^31 / -1 gives lo = 0x80000000, hi = 0.
- Divide by zero (all divide ops): lo = 0xFFFFFFFF, hi = src_a as latched. Same 33-cycle latency; no exception.
- MTHI/MTLO: in IDLE with op_valid=1 and flush=0, write hi (or lo) with src_a at that edge. Single cycle, never busy. While busy they stall via stall_req and are taken once IDLE.
- Back-to-back ops: in the FIX cycle, op_valid is stalled. The following instruction is accepted on the first IDLE edge.
- Flush:
  - Flush high in IDLE blocks accept and any MTHI/MTLO write.
  - Flush high in CALC or FIX returns to IDLE on that edge; hi/lo are not written.
  - Flush has priority over every other event.
- hilo_read only affects stall_req. hi/lo outputs are always the committed values.
- Reset mid-operation aborts immediately. hi/lo return to 0.

Optional Feature:
MULDIV_FAST_MUL_EN.
- Defined: MULT/MULTU skip CALC. The full product is computed with a single-cycle multiply at accept, then the unit enters FIX.
  - hi/lo are written at edge T+1; busy is high for cycle T+1 only.
  - Divide timing is unchanged.
- Undefined: all four ops use the iterative WIDTH-cycle CALC path described above.

Test Plan:
- Reset: drive clr_n low asynchronously between edges -> hi=0, lo=0, busy=0 immediately, no clock needed.
- MULT src_a=0xFFFFFFFD (-3), src_b=5 -> after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high exactly 33 cycles. MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIVU 100/7 -> lo=14, hi=2. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x1234 after 33 cycles.
- Issue MULT, then hilo_read=1 at cycle 5 -> stall_req=1 through the last busy cycle, 0 after. Flush at cycle 10 of a DIV -> busy=0 next cycle; hi/lo keep prior values.
- With MULDIV_FAST_MUL_EN: MULT 6*7 -> lo=42, hi=0 one edge after accept; MTLO 0xABCD in IDLE -> lo=0xABCD next edge, busy stays 0.

Source files
------------

// File: rtl/cpu_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ex_muldiv
// Brief    : Iterative EX-stage multiply/divide unit with HI/LO registers.
//            Define MULDIV_FAST_MUL_EN for single-cycle MULT/MULTU.
// Revision : 1.0 - initial release
// ============================================================================

module cpu_ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hilo_read,
  input  logic             flush,
  output logic             busy,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int                 c_CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [2:0]         c_OP_MULT  = 3'd1;
  localparam logic [2:0]         c_OP_MULTU = 3'd2;
  localparam logic [2:0]         c_OP_DIV   = 3'd3;
  localparam logic [2:0]         c_OP_DIVU  = 3'd4;
  localparam logic [2:0]         c_OP_MTHI  = 3'd5;
  localparam logic [2:0]         c_OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state, w_state_next;

  logic [c_CNT_W-1:0] r_count;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd, r_raw_a, r_hi, r_lo;
  logic               r_is_div, r_div0, r_neg_q, r_neg_r;

  logic               w_idle, w_is_div, w_signed, w_a_neg, w_b_neg;
  logic               w_accept, w_mt_hi, w_mt_lo, w_commit;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_quot, w_rem, w_hi_res, w_lo_res;
  logic [WIDTH:0]     w_mul_sum, w_div_trial;
  logic [2*WIDTH-1:0] w_mul_next, w_div_next, w_prod, w_acc_init;

  assign w_idle   = (r_state == S_IDLE);
  assign w_is_div = (op == c_OP_DIV) || (op == c_OP_DIVU);
  assign w_signed = (op == c_OP_MULT) || (op == c_OP_DIV);
  assign w_a_neg  = w_signed & src_a[WIDTH-1];
  assign w_b_neg  = w_signed & src_b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -src_a : src_a;
  assign w_b_mag  = w_b_neg ? -src_b : src_b;

  assign w_accept = w_idle & op_valid & ~flush & (op >= c_OP_MULT) & (op <= c_OP_DIVU);
  assign w_mt_hi  = w_idle & op_valid & ~flush & (op == c_OP_MTHI);
  assign w_mt_lo  = w_idle & op_valid & ~flush & (op == c_OP_MTLO);
  assign w_commit = (r_state == S_FIX) & ~flush;

  // Divide keeps {remainder, dividend/quotient}; multiply keeps {partial, multiplier}.
`ifdef MULDIV_FAST_MUL_EN
  assign w_acc_init = w_is_div ? {{WIDTH{1'b0}}, w_a_mag}
                               : ({{WIDTH{1'b0}}, w_a_mag} * {{WIDTH{1'b0}}, w_b_mag});
`else
  assign w_acc_init = w_is_div ? {{WIDTH{1'b0}}, w_a_mag} : {{WIDTH{1'b0}}, w_b_mag};
`endif

  assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next  = {w_mul_sum, r_acc[WIDTH-1:1]};
  assign w_div_trial = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_opnd};
  assign w_div_next  = w_div_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                          : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_prod   = r_neg_q ? -r_acc : r_acc;
  assign w_quot   = r_acc[WIDTH-1:0];
  assign w_rem    = r_acc[2*WIDTH-1:WIDTH];
  assign w_lo_res = r_is_div ? (r_div0 ? '1 : (r_neg_q ? -w_quot : w_quot))
                             : w_prod[WIDTH-1:0];
  assign w_hi_res = r_is_div ? (r_div0 ? r_raw_a : (r_neg_r ? -w_rem : w_rem))
                             : w_prod[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
`ifdef MULDIV_FAST_MUL_EN
          w_state_next = w_is_div ? S_CALC : S_FIX;
`else
          w_state_next = S_CALC;
`endif
        end
      end
      S_CALC: begin
        if (flush)                        w_state_next = S_IDLE;
        else if (r_count == c_CNT_LAST)   w_state_next = S_FIX;
      end
      S_FIX:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_count  <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_raw_a  <= '0;
      r_is_div <= 1'b0;
      r_div0   <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      if (w_accept) begin
        r_count  <= '0;
        r_acc    <= w_acc_init;
        r_opnd   <= w_is_div ? w_b_mag : w_a_mag;
        r_raw_a  <= src_a;
        r_is_div <= w_is_div;
        r_div0   <= w_is_div & (src_b == '0);
        r_neg_q  <= w_a_neg ^ w_b_neg;
        r_neg_r  <= w_a_neg;
      end else if ((r_state == S_CALC) && !flush) begin
        r_count <= r_count + c_CNT_ONE;
        r_acc   <= r_is_div ? w_div_next : w_mul_next;
      end

      if (w_commit) begin
        r_hi <= w_hi_res;
        r_lo <= w_lo_res;
      end else begin
        if (w_mt_hi) r_hi <= src_a;
        if (w_mt_lo) r_lo <= src_a;
      end
    end
  end

  assign busy      = ~w_idle;
  assign stall_req = busy & (op_valid | hilo_read);
  assign hi        = r_hi;
  assign lo        = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_cpu_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_ex_muldiv
// Brief    : Scoreboard bench for cpu_ex_muldiv with an arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================

module tb_cpu_ex_muldiv;

  localparam int WIDTH = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = WIDTH + 1;
`endif
  localparam int DIV_LAT = WIDTH + 1;

  logic        clk = 1'b0;
  logic        clr_n = 1'b1;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        hilo_read = 1'b0;
  logic        flush = 1'b0;
  logic        busy, stall_req;
  logic [31:0] hi, lo;

  cpu_ex_muldiv #(.WIDTH(WIDTH)) dut (
    .clk(clk), .clr_n(clr_n), .op_valid(op_valid), .op(op),
    .src_a(src_a), .src_b(src_b), .hilo_read(hilo_read), .flush(flush),
    .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural effect of one instruction, computed with wide arithmetic.
  task automatic model_apply(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd3: begin
        if (b == 32'd0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
        else begin
          q = sa / sb; r = sa % sb;
          p = q; m_lo = p[31:0];
          p = r; m_hi = p[31:0];
        end
      end
      3'd4: begin
        if (b == 32'd0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
  endtask

  // mode: 0 plain, 1 flush in busy cycle k, 2 hilo_read from busy cycle k,
  //       3 reset in busy cycle k, 4 flush on the accept edge
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int mode, input int k);
    int   guard;
    bit   is_long;
    exp_t e;
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    guard = 0;
    while (busy && guard < 200) begin @(posedge clk); #1; guard++; end
    if (guard >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL idle_wait: got busy=1 required busy=0 within 200 cycles");
    end
    if (mode == 4) flush = 1'b1;
    @(posedge clk);
    is_long = (o >= 3'd1) && (o <= 3'd4);
    if (mode == 4) begin
      #1; flush = 1'b0; op_valid = 1'b0;
      check("flush_idle_hi", hi, m_hi);
      check("flush_idle_lo", lo, m_lo);
      return;
    end
    if (is_long) begin
      e.len = (o <= 3'd2) ? MUL_LAT : DIV_LAT;
      if (mode == 1 || mode == 3) e.len = k;
      else model_apply(o, a, b);
      e.hi = m_hi; e.lo = m_lo;
      sb_q.push_back(e);
    end else begin
      model_apply(o, a, b);
    end
    #1; op_valid = 1'b0;
    if (!is_long) begin
      check("short_hi", hi, m_hi);
      check("short_lo", lo, m_lo);
      return;
    end
    if (mode == 1) begin
      repeat (k - 1) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
    end else if (mode == 2) begin
      repeat (k - 1) begin @(posedge clk); #1; end
      hilo_read = 1'b1;
      guard = 0;
      while (busy && guard < 100) begin @(posedge clk); #1; guard++; end
      hilo_read = 1'b0;
    end else if (mode == 3) begin
      repeat (k - 1) begin @(posedge clk); #1; end
      #2; clr_n = 1'b0;
      #1;
      check("areset_hi", hi, 32'd0);
      check("areset_lo", lo, 32'd0);
      check("areset_busy", {31'd0, busy}, 32'd0);
      m_hi = 32'd0; m_lo = 32'd0;
      @(negedge clk);
      @(posedge clk); #1;
      clr_n = 1'b1;
    end
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: tracks expected busy window per queued op and checks results on completion.
  initial begin : monitor
    int   run;
    logic exp_busy;
    exp_t e;
    run = 0;
    forever begin
      @(negedge clk);
      if (!clr_n) begin
        sb_q.delete();
        run = 0;
      end else begin
        exp_busy = (sb_q.size() > 0) && (run < sb_q[0].len);
        check("busy", {31'd0, busy}, {31'd0, exp_busy});
        check("stall_req", {31'd0, stall_req}, {31'd0, exp_busy & (op_valid | hilo_read)});
        if (exp_busy) run++;
        else if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          run = 0;
          check("result_hi", hi, e.hi);
          check("result_lo", lo, e.lo);
        end
      end
    end
  end

  initial begin : stimulus
    logic [2:0] o;
    int         m, k, lat, guard;
    #3 clr_n = 1'b0;
    #1;
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    clr_n = 1'b1;

    issue(3'd1, 32'hFFFF_FFFD, 32'd5, 0, 0);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    issue(3'd4, 32'd100, 32'd7, 0, 0);
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 0, 0);
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    issue(3'd4, 32'h0000_1234, 32'd0, 0, 0);
    issue(3'd3, 32'h0000_1234, 32'd0, 0, 0);
    issue(3'd1, 32'd6, 32'd7, 0, 0);
    issue(3'd1, 32'h1234_5678, 32'h8765_4321, 2, (MUL_LAT >= 5) ? 5 : 1);
    issue(3'd3, 32'd1000, 32'd3, 1, 10);
    issue(3'd6, 32'h0000_ABCD, 32'd0, 0, 0);
    issue(3'd5, 32'h5555_AAAA, 32'd0, 0, 0);
    issue(3'd4, 32'hDEAD_BEEF, 32'd17, 1, DIV_LAT);
    issue(3'd5, 32'h1111_2222, 32'd0, 4, 0);
    issue(3'd4, 32'd99, 32'd9, 3, 7);
    issue(3'd0, 32'h7777_7777, 32'd3, 0, 0);

    for (int i = 0; i < 60; i++) begin
      m = $urandom_range(0, 99);
      if (m < 85)      o = 3'($urandom_range(1, 4));
      else if (m < 95) o = 3'($urandom_range(5, 6));
      else             o = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd7;
      lat = (o <= 3'd2) ? MUL_LAT : DIV_LAT;
      k = $urandom_range(1, lat);
      if (o >= 3'd1 && o <= 3'd4) begin
        case ($urandom_range(0, 9))
          0: m = 1;
          1: m = 2;
          2: m = 3;
          3: m = 4;
          default: m = 0;
        endcase
      end else begin
        m = ($urandom_range(0, 4) == 0) ? 4 : 0;
      end
      issue(o, rand_val(), rand_val(), m, k);
    end

    op_valid = 1'b0;
    guard = 0;
    while (sb_q.size() > 0 && guard < 200) begin @(posedge clk); #1; guard++; end
    if (sb_q.size() > 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain: got %0d pending required 0", sb_q.size());
    end
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
